// File: rtl/mul_operand_sequencer_pkg.sv
// Shared types for the multiplier operand sequencer: FSM state encoding and default width.
package mul_operand_sequencer_pkg;

  localparam int DEF_W = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_LD_A  = 3'd2;
  localparam logic [2:0] ST_LD_B  = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_START = ST_START,
    S_LD_A  = ST_LD_A,
    S_LD_B  = ST_LD_B,
    S_WAIT  = ST_WAIT
  } state_t;

endpackage

// File: rtl/mul_operand_sequencer_fifo.sv
// Operand-pair FIFO: synchronous, show-ahead head, no push/pop bypass when full.
module opnd_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mul_operand_sequencer.sv
// Feeds buffered operand pairs into the serial-load repeated-addition multiplier and collects products.
module mul_operand_sequencer
  import mul_operand_sequencer_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_prod,
  output logic         out_err,
  output logic         mul_start,
  output logic [W-1:0] mul_data,
  input  logic         mul_done,
  input  logic [W-1:0] mul_prod,
  output logic         busy
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  state_t        state;
  logic [W-1:0]  op_a, op_b;
  logic [CW-1:0] cnt;
  logic [2*W-1:0] head;
  logic          fifo_full, fifo_empty, pop;
  logic [W-1:0]  head_a, head_b;

  assign in_ready = rst_n && !fifo_full;
  assign pop      = (state == S_IDLE) && !fifo_empty && !out_valid;
  assign head_a   = head[2*W-1:W];
  assign head_b   = head[W-1:0];
  assign busy     = (state != S_IDLE);

  opnd_fifo #(.WIDTH(2*W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid && in_ready),
    .wdata ({in_a, in_b}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_a      <= '0;
      op_b      <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_prod  <= '0;
      out_err   <= 1'b0;
      mul_start <= 1'b0;
      mul_data  <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        S_IDLE: if (pop) begin
          op_a <= head_a;
          op_b <= head_b;
          // A zero operand has a known product; never bother the multiplier.
          if (head_a == '0 || head_b == '0) begin
            out_prod  <= '0;
            out_err   <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            state     <= S_START;
            mul_start <= 1'b1;
            mul_data  <= head_a;
          end
        end
        S_START: begin
          mul_start <= 1'b0;
          mul_data  <= op_a;
          state     <= S_LD_A;
        end
        S_LD_A: begin
          mul_data <= op_b;
          state    <= S_LD_B;
        end
        S_LD_B: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // done is only trusted here; a level left over from the last op is high earlier.
          cnt <= cnt + CW'(1);
          if (mul_done) begin
            out_prod  <= mul_prod;
            out_err   <= 1'b0;
            out_valid <= 1'b1;
            state     <= S_IDLE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            out_prod  <= '0;
            out_err   <= 1'b1;
            out_valid <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
